// File: rtl/game_msg_sm.sv
// Game-flow FSM selecting the full-screen message, tracking level/lives and timing LEVEL_UP/HIT.
// Optional build macro MSG_BLINK_EN blinks the static messages (open, pause, win, game-over).
module game_msg_sm #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned HOLD_TICKS  = 2,
    parameter int unsigned N_LEVELS    = 3,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       pause_key,
    input  logic       player_hit,
    input  logic       level_done,
    input  logic       drawing_request,
    output logic [2:0] msg_sel,
    output logic       msg_DR,
    output logic       game_active,
    output logic       new_game,
    output logic [3:0] level,
    output logic [3:0] lives
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

    if (TICK_DIV < 2 || HOLD_TICKS < 1 || HOLD_TICKS > 15 || N_LEVELS < 1 ||
        N_LEVELS > 15 || LIVES < 1 || LIVES > 15 || BLINK_TICKS < 1) begin : g_cfg_err
        $error("game_msg_sm: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_OPEN, S_PLAY, S_PAUSE, S_LVLUP, S_HIT, S_WIN, S_OVER
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_start_q, r_pause_q, r_keys_armed;
    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_hold;
    logic [3:0]    r_level, w_level_nxt;
    logic [3:0]    r_lives, w_lives_nxt;
    logic [2:0]    r_msg_sel, w_msg_sel_nxt;
    logic          r_game_active, r_new_game, w_new_game_nxt;
    logic          w_start_e, w_pause_e, w_tick, w_state_chg, w_blink_ok;

    // Keys held through reset must not count as a press: edges are ignored until the first clock has sampled them.
    assign w_start_e   = start     & ~r_start_q & r_keys_armed;
    assign w_pause_e   = pause_key & ~r_pause_q & r_keys_armed;
    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_state_chg = (w_state_nxt != r_state);

    // State register plus all registered outputs, timers and key history
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_OPEN;
            r_start_q     <= 1'b0;
            r_pause_q     <= 1'b0;
            r_keys_armed  <= 1'b0;
            r_tick_cnt    <= '0;
            r_hold        <= 4'd0;
            r_level       <= 4'd0;
            r_lives       <= 4'(LIVES);
            r_msg_sel     <= 3'd1;
            r_game_active <= 1'b0;
            r_new_game    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_q     <= start;
            r_pause_q     <= pause_key;
            r_keys_armed  <= 1'b1;
            r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_level       <= w_level_nxt;
            r_lives       <= w_lives_nxt;
            r_msg_sel     <= w_msg_sel_nxt;
            r_game_active <= (w_state_nxt == S_PLAY);
            r_new_game    <= w_new_game_nxt;
            if (w_state_chg)
                r_hold <= 4'd0;
            else if (w_tick && r_hold != 4'(HOLD_TICKS))
                r_hold <= r_hold + 4'd1;
        end
    end

    // Next-state, level/lives bookkeeping and message select
    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_lives_nxt    = r_lives;
        w_new_game_nxt = 1'b0;
        w_msg_sel_nxt  = 3'd0;
        case (r_state)
            S_OPEN: if (w_start_e) begin
                w_state_nxt    = S_PLAY;
                w_new_game_nxt = 1'b1;
                w_level_nxt    = 4'd0;
                w_lives_nxt    = 4'(LIVES);
            end
            S_PLAY: if (player_hit) begin
                if (r_lives == 4'd1) begin
                    w_state_nxt = S_OVER;
                    w_lives_nxt = 4'd0;
                end else begin
                    w_state_nxt = S_HIT;
                    w_lives_nxt = r_lives - 4'd1;
                end
            end else if (level_done) begin
                w_state_nxt = (r_level == 4'(N_LEVELS - 1)) ? S_WIN : S_LVLUP;
            end else if (w_pause_e) begin
                w_state_nxt = S_PAUSE;
            end
            S_PAUSE: if (w_pause_e || w_start_e) w_state_nxt = S_PLAY;
            S_LVLUP: if (r_hold == 4'(HOLD_TICKS)) begin
                w_state_nxt = S_PLAY;
                w_level_nxt = r_level + 4'd1;
            end
            S_HIT: if (r_hold == 4'(HOLD_TICKS)) w_state_nxt = S_PLAY;
            S_WIN, S_OVER: if (w_start_e) w_state_nxt = S_OPEN;
            default: w_state_nxt = S_OPEN;
        endcase
        case (w_state_nxt)
            S_OPEN:  w_msg_sel_nxt = 3'd1;
            S_PAUSE: w_msg_sel_nxt = 3'd2;
            S_LVLUP: w_msg_sel_nxt = 3'd3;
            S_HIT:   w_msg_sel_nxt = 3'd4;
            S_WIN:   w_msg_sel_nxt = 3'd5;
            S_OVER:  w_msg_sel_nxt = 3'd6;
            default: w_msg_sel_nxt = 3'd0;
        endcase
    end

`ifdef MSG_BLINK_EN
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    // Blink phase restarts visible on every state change so a new message never starts dark
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_state_chg) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_blink_ok = r_phase || (r_state == S_LVLUP) || (r_state == S_HIT);
`else
    assign w_blink_ok = 1'b1;
`endif

    assign msg_sel     = r_msg_sel;
    assign msg_DR      = drawing_request & (r_msg_sel != 3'd0) & w_blink_ok;
    assign game_active = r_game_active;
    assign new_game    = r_new_game;
    assign level       = r_level;
    assign lives       = r_lives;

endmodule

// File: tb/tb_game_msg_sm.sv
// Directed self-checking bench for game_msg_sm with small timing parameters.
module tb_game_msg_sm;

    logic       clk = 1'b0;
    logic       resetN, start, pause_key, player_hit, level_done, drawing_request;
    logic [2:0] msg_sel;
    logic       msg_DR, game_active, new_game;
    logic [3:0] level, lives;

    int n_checks = 0;
    int n_errors = 0;

    game_msg_sm #(
        .TICK_DIV(4), .HOLD_TICKS(2), .N_LEVELS(2), .LIVES(2), .BLINK_TICKS(1)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start), .pause_key(pause_key),
        .player_hit(player_hit), .level_done(level_done),
        .drawing_request(drawing_request), .msg_sel(msg_sel), .msg_DR(msg_DR),
        .game_active(game_active), .new_game(new_game), .level(level), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_msg(input string tag, input int exp, input int max_cyc);
        int n = 0;
        while (int'(msg_sel) != exp && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, int'(msg_sel), exp);
    endtask

    task automatic press_start();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
    endtask

    initial begin
        int ones;
        resetN = 1'b0; start = 1'b0; pause_key = 1'b0;
        player_hit = 1'b0; level_done = 1'b0; drawing_request = 1'b1;
        step(2);
        check("rst_msg_sel", int'(msg_sel), 1);
        check("rst_level", int'(level), 0);
        check("rst_lives", int'(lives), 2);
        check("rst_game_active", int'(game_active), 0);
        check("rst_new_game", int'(new_game), 0);
        check("rst_msg_DR", int'(msg_DR), 1);
        resetN = 1'b1;
        step(2);
        check("open_idle_msg_sel", int'(msg_sel), 1);

        // New game
        start = 1'b1;
        step();
        check("start_msg_sel", int'(msg_sel), 0);
        check("start_game_active", int'(game_active), 1);
        check("start_new_game", int'(new_game), 1);
        check("start_level", int'(level), 0);
        check("start_lives", int'(lives), 2);
        check("play_msg_DR", int'(msg_DR), 0);
        step();
        check("new_game_one_cycle", int'(new_game), 0);
        start = 1'b0;

        // Level up then win
        level_done = 1'b1; step(); level_done = 1'b0;
        check("lvlup_msg_sel", int'(msg_sel), 3);
        check("lvlup_game_active", int'(game_active), 0);
        check("lvlup_level_held", int'(level), 0);
        wait_msg("lvlup_return", 0, 20);
        check("lvlup_level", int'(level), 1);
        check("lvlup_back_active", int'(game_active), 1);
        level_done = 1'b1; step(); level_done = 1'b0;
        check("win_msg_sel", int'(msg_sel), 5);
        press_start();
        check("win_to_open", int'(msg_sel), 1);
        check("open_level_kept", int'(level), 1);
        press_start();
        check("new_game2_level", int'(level), 0);
        check("new_game2_lives", int'(lives), 2);
        check("new_game2_pulse", int'(new_game), 1);

        // Hit beats level_done, then game over
        player_hit = 1'b1; level_done = 1'b1; step();
        player_hit = 1'b0; level_done = 1'b0;
        check("hit_msg_sel", int'(msg_sel), 4);
        check("hit_lives", int'(lives), 1);
        check("hit_level", int'(level), 0);
        check("hit_msg_DR", int'(msg_DR), 1);
        wait_msg("hit_return", 0, 20);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        check("over_msg_sel", int'(msg_sel), 6);
        check("over_lives", int'(lives), 0);
        press_start();
        check("over_to_open", int'(msg_sel), 1);
        check("open_lives_kept", int'(lives), 0);
        press_start();
        check("new_game3", int'(msg_sel), 0);

        // Pause, pulses ignored while paused
        pause_key = 1'b1; step();
        check("pause_msg_sel", int'(msg_sel), 2);
        pause_key = 1'b0;
        player_hit = 1'b1; step(); player_hit = 1'b0;
        level_done = 1'b1; step(); level_done = 1'b0;
        check("pause_hit_ignored", int'(lives), 2);
        check("pause_still", int'(msg_sel), 2);
        pause_key = 1'b1; step(); pause_key = 1'b0;
        check("unpause_msg_sel", int'(msg_sel), 0);

        // Start held through reset is not a press
        resetN = 1'b0; #1;
        check("async_rst_play", int'(msg_sel), 1);
        step(2);
        resetN = 1'b1;
        step(3);
        check("held_start_no_edge", int'(msg_sel), 1);
        press_start();
        check("repress_start", int'(msg_sel), 0);
        start = 1'b0;

        // Async reset in the middle of LEVEL_UP hold
        player_hit = 1'b1; step(); player_hit = 1'b0;
        wait_msg("hit2_return", 0, 20);
        check("pre_rst_lives", int'(lives), 1);
        level_done = 1'b1; step(); level_done = 1'b0;
        check("lvlup2_msg_sel", int'(msg_sel), 3);
        step(2);
        resetN = 1'b0; #1;
        check("async_rst_msg_sel", int'(msg_sel), 1);
        check("async_rst_level", int'(level), 0);
        check("async_rst_lives", int'(lives), 2);
        check("async_rst_active", int'(game_active), 0);
        step();
        resetN = 1'b1;

        // Static message visibility over two blink periods
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (msg_DR) ones++;
        end
`ifdef MSG_BLINK_EN
        check("blink_open_half_on", ones, 8);
`else
        check("open_no_blink", ones, 16);
`endif
        drawing_request = 1'b0; #1;
        check("dr_low_msg_DR", int'(msg_DR), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
